// File: rtl/gpr_writeback.sv
// gpr_writeback: writeback sequencer for the GPR file write port.
// Accepts one retiring instruction, selects ALU, load or link data, waits for
// load data when needed (with an optional timeout), aligns/extends it and
// issues exactly one register write. All outputs are registered on posedge.
// All buses use [0:N-1] ordering: bit 0 is the MSB.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   wb_valid / wb_ready  retire handshake (accepted only while wb_ready=1)
//   wb_src               00 ALU, 01 load, 10 link, 11 no write
//   wb_Rt, wb_Rd         instruction register fields
//   wb_Rdst, wb_jal      destination select (Rd vs Rt, r31 for jal)
//   alu_result, link_pc  ALU result and jal return address
//   ld_size, ld_signed   load size (00 byte, 01 half, 10 word) and extension
//   ld_offset            low address bits of the load
//   mem_rdata/mem_rvalid load return word and its valid strobe
//   regWr                one-cycle GPR write enable
//   Rt, Rd, Rdst         held register selects to the GPR file
//   jal_instr            held jal flag to the GPR file
//   busW                 write data
//   wb_done, wb_error    one-cycle completion / error pulses
module gpr_writeback #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [0:1]  wb_src,
    input  logic [0:4]  wb_Rt,
    input  logic [0:4]  wb_Rd,
    input  logic        wb_Rdst,
    input  logic        wb_jal,
    input  logic [0:31] alu_result,
    input  logic [0:31] link_pc,
    input  logic [0:1]  ld_size,
    input  logic        ld_signed,
    input  logic [0:1]  ld_offset,
    input  logic [0:31] mem_rdata,
    input  logic        mem_rvalid,
    output logic        regWr,
    output logic [0:4]  Rt,
    output logic [0:4]  Rd,
    output logic        Rdst,
    output logic        jal_instr,
    output logic [0:31] busW,
    output logic        wb_done,
    output logic        wb_error
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Timeout of 0 disables expiry entirely.
    localparam bit             TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MEM,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             sgn_q;

    // Numeric (descending) views of the ascending input fields.
    logic [1:0]  src_in;
    logic [1:0]  size_in;
    logic [1:0]  off_in;
    logic        bad_align;
    logic        dest_zero_in;
    logic        dest_zero_q;

    logic [31:0] rdata_w;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    // Accept-time decode: alignment check and r0 destination detection.
    always_comb begin
        src_in    = wb_src;
        size_in   = ld_size;
        off_in    = ld_offset;
        bad_align = (size_in == SZ_RSVD)
                 || ((size_in == SZ_HALF) && off_in[0])
                 || ((size_in == SZ_WORD) && (off_in != 2'b00));
        dest_zero_in = wb_jal ? 1'b0 : (wb_Rdst ? (wb_Rd == 5'd0) : (wb_Rt == 5'd0));
        dest_zero_q  = jal_instr ? 1'b0 : (Rdst ? (Rd == 5'd0) : (Rt == 5'd0));
    end

    // Load extraction: offset 0 addresses the most significant byte.
    always_comb begin
        rdata_w = mem_rdata;
        byte_v  = 8'(rdata_w >> {2'(2'd3 - off_q), 3'b000});
        half_v  = 16'(rdata_w >> {~off_q[1], 4'b0000});
        case (size_q)
            SZ_BYTE: load_data = sgn_q ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
            SZ_HALF: load_data = sgn_q ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
            default: load_data = rdata_w;
        endcase
    end

    // Sequencer: outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wb_ready  <= 1'b1;
            regWr     <= 1'b0;
            wb_done   <= 1'b0;
            wb_error  <= 1'b0;
            busW      <= '0;
            Rt        <= '0;
            Rd        <= '0;
            Rdst      <= 1'b0;
            jal_instr <= 1'b0;
            cnt       <= '0;
            size_q    <= '0;
            off_q     <= '0;
            sgn_q     <= 1'b0;
        end else begin
            regWr    <= 1'b0;
            wb_done  <= 1'b0;
            wb_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wb_valid) begin
                        wb_ready  <= 1'b0;
                        Rt        <= wb_Rt;
                        Rd        <= wb_Rd;
                        Rdst      <= wb_Rdst;
                        jal_instr <= wb_jal;
                        size_q    <= size_in;
                        off_q     <= off_in;
                        sgn_q     <= ld_signed;
                        cnt       <= '0;
                        case (src_in)
                            SRC_ALU, SRC_LINK: begin
                                busW    <= (src_in == SRC_ALU) ? alu_result : link_pc;
                                regWr   <= ~dest_zero_in;
                                wb_done <= 1'b1;
                                state   <= S_WRITE;
                            end
                            SRC_MEM: begin
                                busW <= '0;
                                if (bad_align) begin
                                    wb_done  <= 1'b1;
                                    wb_error <= 1'b1;
                                    state    <= S_ERROR;
                                end else begin
                                    state <= S_WAIT_MEM;
                                end
                            end
                            default: begin
                                busW    <= '0;
                                wb_done <= 1'b1;
                                state   <= S_DONE;
                            end
                        endcase
                    end
                end
                S_WAIT_MEM: begin
                    cnt <= CNT_W'(cnt + 1'b1);
                    // Data wins over a coincident timeout.
                    if (mem_rvalid) begin
                        busW    <= load_data;
                        regWr   <= ~dest_zero_q;
                        wb_done <= 1'b1;
                        state   <= S_WRITE;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        wb_done  <= 1'b1;
                        wb_error <= 1'b1;
                        state    <= S_ERROR;
                    end
                end
                S_WRITE, S_DONE, S_ERROR: begin
                    wb_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    wb_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_writeback.sv
module tb_gpr_writeback;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [0:1]  wb_src;
    logic [0:4]  wb_Rt;
    logic [0:4]  wb_Rd;
    logic        wb_Rdst;
    logic        wb_jal;
    logic [0:31] alu_result;
    logic [0:31] link_pc;
    logic [0:1]  ld_size;
    logic        ld_signed;
    logic [0:1]  ld_offset;
    logic [0:31] mem_rdata;
    logic        mem_rvalid;
    logic        regWr;
    logic [0:4]  Rt;
    logic [0:4]  Rd;
    logic        Rdst;
    logic        jal_instr;
    logic [0:31] busW;
    logic        wb_done;
    logic        wb_error;

    int checks = 0;
    int errors = 0;

    gpr_writeback #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_src     (wb_src),
        .wb_Rt      (wb_Rt),
        .wb_Rd      (wb_Rd),
        .wb_Rdst    (wb_Rdst),
        .wb_jal     (wb_jal),
        .alu_result (alu_result),
        .link_pc    (link_pc),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .ld_offset  (ld_offset),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .regWr      (regWr),
        .Rt         (Rt),
        .Rd         (Rd),
        .Rdst       (Rdst),
        .jal_instr  (jal_instr),
        .busW       (busW),
        .wb_done    (wb_done),
        .wb_error   (wb_error)
    );

    always #5 clk = ~clk;

    // One transaction: instruction fields, load return, and expected write.
    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rdst;
        logic        jal;
        logic [31:0] alu;
        logic [31:0] link;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        int          dly;      // edges after accept at which rvalid is sampled
        logic [31:0] rdata;
        logic        exp_wr;
        logic        exp_err;
        logic [31:0] exp_busw;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_fields(input vec_t v);
        wb_src     = v.src;
        wb_Rt      = v.rt;
        wb_Rd      = v.rd;
        wb_Rdst    = v.rdst;
        wb_jal     = v.jal;
        alu_result = v.alu;
        link_pc    = v.link;
        ld_size    = v.size;
        ld_signed  = v.sgn;
        ld_offset  = v.off;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, " ready_before"}, 32'(wb_ready), 32'd1);
        drive_fields(v);
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        if (v.src == 2'b01 && !v.exp_err) begin
            chk({tag, " wait_done"}, 32'(wb_done), 32'd0);
            chk({tag, " wait_ready"}, 32'(wb_ready), 32'd0);
            for (int i = 1; i < v.dly; i++) begin
                step();
                chk({tag, " wait_regwr"}, 32'(regWr), 32'd0);
            end
            mem_rdata  = v.rdata;
            mem_rvalid = 1'b1;
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
        end
        chk({tag, " regwr"}, 32'(regWr), 32'(v.exp_wr));
        chk({tag, " done"}, 32'(wb_done), 32'd1);
        chk({tag, " error"}, 32'(wb_error), 32'(v.exp_err));
        chk({tag, " sel"}, 32'({Rt, Rd, Rdst, jal_instr}), 32'({v.rt, v.rd, v.rdst, v.jal}));
        if (v.exp_wr)
            chk({tag, " busw"}, busW, v.exp_busw);
        step();
        chk({tag, " idle_regwr"}, 32'(regWr), 32'd0);
        chk({tag, " idle_done"}, 32'(wb_done), 32'd0);
        chk({tag, " idle_ready"}, 32'(wb_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        clk        = 1'b0;
        reset      = 1'b1;
        wb_valid   = 1'b0;
        wb_src     = 2'b00;
        wb_Rt      = 5'd0;
        wb_Rd      = 5'd0;
        wb_Rdst    = 1'b0;
        wb_jal     = 1'b0;
        alu_result = 32'h0;
        link_pc    = 32'h0;
        ld_size    = 2'b00;
        ld_signed  = 1'b0;
        ld_offset  = 2'b00;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;

        //          src    rt     rd     rdst  jal   alu            link           size   sgn   off  dly rdata          wr    err   busW
        vecs[0]  = '{2'd0, 5'd9,  5'd5,  1'b1, 1'b0, 32'h12345678, 32'h0,         2'd0, 1'b0, 2'd0, 0, 32'h0,         1'b1, 1'b0, 32'h12345678};
        vecs[1]  = '{2'd0, 5'd0,  5'd3,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0,         2'd0, 1'b0, 2'd0, 0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[2]  = '{2'd2, 5'd0,  5'd0,  1'b0, 1'b1, 32'h0,        32'h00000108,  2'd0, 1'b0, 2'd0, 0, 32'h0,         1'b1, 1'b0, 32'h00000108};
        vecs[3]  = '{2'd0, 5'd7,  5'd0,  1'b1, 1'b0, 32'h11110000, 32'h0,         2'd0, 1'b0, 2'd0, 0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[4]  = '{2'd0, 5'd0,  5'd0,  1'b0, 1'b1, 32'h000000AA, 32'hFFFF0000,  2'd0, 1'b0, 2'd0, 0, 32'h0,         1'b1, 1'b0, 32'h000000AA};
        vecs[5]  = '{2'd3, 5'd6,  5'd8,  1'b1, 1'b0, 32'h77777777, 32'h0,         2'd0, 1'b0, 2'd0, 0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[6]  = '{2'd1, 5'd4,  5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd0, 1'b1, 2'd3, 3, 32'h000000F0,  1'b1, 1'b0, 32'hFFFFFFF0};
        vecs[7]  = '{2'd1, 5'd10, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd1, 1'b0, 2'd2, 1, 32'hAAAA8001,  1'b1, 1'b0, 32'h00008001};
        vecs[8]  = '{2'd1, 5'd11, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd1, 1'b1, 2'd1, 0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[9]  = '{2'd1, 5'd12, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd2, 1'b0, 2'd0, 4, 32'hCAFEBABE,  1'b1, 1'b0, 32'hCAFEBABE};
        vecs[10] = '{2'd1, 5'd13, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd0, 1'b0, 2'd0, 2, 32'h80123456,  1'b1, 1'b0, 32'h00000080};
        vecs[11] = '{2'd1, 5'd14, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd0, 1'b1, 2'd1, 1, 32'h127F3456,  1'b1, 1'b0, 32'h0000007F};
        vecs[12] = '{2'd1, 5'd15, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd1, 1'b1, 2'd0, 2, 32'h9ABC1234,  1'b1, 1'b0, 32'hFFFF9ABC};
        vecs[13] = '{2'd1, 5'd16, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd2, 1'b0, 2'd2, 0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[14] = '{2'd1, 5'd17, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd3, 1'b0, 2'd0, 0, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[15] = '{2'd1, 5'd0,  5'd9,  1'b0, 1'b0, 32'h0,        32'h0,         2'd0, 1'b1, 2'd3, 1, 32'h000000FF,  1'b0, 1'b0, 32'h0};
        vecs[16] = '{2'd1, 5'd18, 5'd0,  1'b0, 1'b0, 32'h0,        32'h0,         2'd0, 1'b0, 2'd1, 1, 32'h00FF0000,  1'b1, 1'b0, 32'h000000FF};

        // Reset state while reset is held.
        step();
        step();
        chk("rst_ready", 32'(wb_ready), 32'd1);
        chk("rst_regwr", 32'(regWr), 32'd0);
        chk("rst_done", 32'(wb_done), 32'd0);
        chk("rst_error", 32'(wb_error), 32'd0);
        chk("rst_busw", busW, 32'd0);
        chk("rst_sel", 32'({Rt, Rd, Rdst, jal_instr}), 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(wb_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            run_vec(i, vecs[i]);

        // Timeout: no rvalid, error lands in the fifth cycle after accept.
        v = vecs[6];
        drive_fields(v);
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_wait%0d_done", i), 32'(wb_done), 32'd0);
            chk($sformatf("to_wait%0d_regwr", i), 32'(regWr), 32'd0);
            step();
        end
        chk("to_done", 32'(wb_done), 32'd1);
        chk("to_error", 32'(wb_error), 32'd1);
        chk("to_regwr", 32'(regWr), 32'd0);
        step();
        chk("to_after_ready", 32'(wb_ready), 32'd1);
        chk("to_after_error", 32'(wb_error), 32'd0);

        // wb_valid held while busy is ignored; accepted again once idle.
        v = vecs[7];
        drive_fields(v);
        wb_valid = 1'b1;
        step();
        wb_src     = 2'b00;
        wb_Rt      = 5'd20;
        wb_Rd      = 5'd21;
        wb_Rdst    = 1'b1;
        alu_result = 32'h0BADF00D;
        step();
        chk("busy_ready", 32'(wb_ready), 32'd0);
        chk("busy_regwr", 32'(regWr), 32'd0);
        mem_rdata  = 32'h1234FEDC;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("busy_ld_regwr", 32'(regWr), 32'd1);
        chk("busy_ld_busw", busW, 32'h0000FEDC);
        chk("busy_ld_rt", 32'(Rt), 32'd10);
        step();
        chk("busy_idle_regwr", 32'(regWr), 32'd0);
        chk("busy_idle_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        chk("b2b_regwr", 32'(regWr), 32'd1);
        chk("b2b_busw", busW, 32'h0BADF00D);
        chk("b2b_rd", 32'(Rd), 32'd21);
        step();

        // Reset during WAIT_MEM: outputs clear at once, late rvalid is ignored.
        v = vecs[6];
        drive_fields(v);
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(wb_ready), 32'd1);
        chk("mid_rst_regwr", 32'(regWr), 32'd0);
        chk("mid_rst_rt", 32'(Rt), 32'd0);
        mem_rdata  = 32'h000000F0;
        mem_rvalid = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_rst_rv%0d_regwr", i), 32'(regWr), 32'd0);
            chk($sformatf("mid_rst_rv%0d_done", i), 32'(wb_done), 32'd0);
            chk($sformatf("mid_rst_rv%0d_busw", i), busW, 32'd0);
        end
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
